grant_event_packer: RTL and testbench

GRANT_EVENT_PACKER -- requirements
Module: grant_event_packer

---
 rtl/grant_event_packer.sv | 148 ++++++++++++++
 tb/tb_grant_event_packer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grant_event_packer.sv
`default_nettype none
// ============================================================================
//  Module      : grant_event_packer
//  Description : Converts the one-hot grant vector of a round-robin arbiter
//                into timestamped address events held in a small
//                first-word-fall-through FIFO with a valid/ready read port.
//
//                Ports:
//                  clk_i          rising-edge clock
//                  rst_i          asynchronous, active-high reset
//                  gnt_i          grant vector, sampled every cycle
//                  evt_valid_o    an event is present at the FIFO head
//                  evt_ready_i    consumer accepts the head event
//                  evt_addr_o     grant index of the head event (0 if empty)
//                  evt_ts_o       timestamp of the head event (0 if empty)
//                  fifo_level_o   current FIFO occupancy
//                  ovf_cnt_o      saturating count of dropped events
//                  multi_err_o    sticky: a grant vector had >1 bit set
//
//                Build option:
//                  GRANT_EVENT_PACKER_DEDUP_EN  when defined, a grant only
//                  produces an event if it differs from the grant vector of
//                  the previous cycle, so a held grant yields one event.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module grant_event_packer #(
    parameter int NUM_REQUESTS   = 256,
    parameter int FIFO_DEPTH     = 8,
    parameter int TS_WIDTH       = 16,
    localparam int ADDR_WIDTH    = $clog2(NUM_REQUESTS)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQUESTS-1:0]       gnt_i,
    output logic                          evt_valid_o,
    input  logic                          evt_ready_i,
    output logic [ADDR_WIDTH-1:0]         evt_addr_o,
    output logic [TS_WIDTH-1:0]           evt_ts_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [7:0]                    ovf_cnt_o,
    output logic                          multi_err_o
);

    localparam int c_PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int c_ENTRY_WIDTH = TS_WIDTH + ADDR_WIDTH;
    localparam logic [c_PTR_WIDTH:0] c_DEPTH_LVL = (c_PTR_WIDTH + 1)'(FIFO_DEPTH);

    logic [TS_WIDTH-1:0]      r_ts;
    logic [c_PTR_WIDTH-1:0]   r_wr_ptr;
    logic [c_PTR_WIDTH-1:0]   r_rd_ptr;
    logic [c_PTR_WIDTH:0]     r_level;
    logic [7:0]               r_ovf_cnt;
    logic                     r_multi_err;
    logic [c_ENTRY_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0]    w_addr;
    logic                     w_multi;
    logic                     w_qualify;
    logic                     w_full;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_drop;
    logic [c_ENTRY_WIDTH-1:0] w_head;

    // Priority encoder: scanning from the top down leaves the lowest set
    // index, which is the address used when several bits are set.
    always_comb begin
        w_addr = '0;
        for (int i = NUM_REQUESTS - 1; i >= 0; i--) begin
            if (gnt_i[i]) begin
                w_addr = ADDR_WIDTH'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if >1 bit was set.
    assign w_multi = |(gnt_i & (gnt_i - NUM_REQUESTS'(1)));

`ifdef GRANT_EVENT_PACKER_DEDUP_EN
    logic [NUM_REQUESTS-1:0] r_prev_gnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prev_gnt <= '0;
        end else begin
            r_prev_gnt <= gnt_i;
        end
    end

    assign w_qualify = (|gnt_i) && (gnt_i != r_prev_gnt);
`else
    assign w_qualify = |gnt_i;
`endif

    assign evt_valid_o = (r_level != '0);
    assign w_full      = (r_level == c_DEPTH_LVL);
    assign w_pop       = evt_valid_o & evt_ready_i;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push      = w_qualify & (~w_full | w_pop);
    assign w_drop      = w_qualify & w_full & ~w_pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ts        <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_ovf_cnt   <= '0;
            r_multi_err <= 1'b0;
        end else begin
            r_ts <= r_ts + TS_WIDTH'(1);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (c_PTR_WIDTH + 1)'(1);
                2'b01:   r_level <= r_level - (c_PTR_WIDTH + 1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop && (r_ovf_cnt != 8'hFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
            if (w_multi) begin
                r_multi_err <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (w_push && !rst_i) begin
            r_mem[r_wr_ptr] <= {r_ts, w_addr};
        end
    end

    assign w_head       = r_mem[r_rd_ptr];
    assign evt_addr_o   = evt_valid_o ? w_head[ADDR_WIDTH-1:0] : '0;
    assign evt_ts_o     = evt_valid_o ? w_head[c_ENTRY_WIDTH-1:ADDR_WIDTH] : '0;
    assign fifo_level_o = r_level;
    assign ovf_cnt_o    = r_ovf_cnt;
    assign multi_err_o  = r_multi_err;

endmodule
`default_nettype wire

// File: tb/tb_grant_event_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grant_event_packer
//  Description : Self-checking bench for grant_event_packer (default
//                parameters). Expected behaviour comes from a queue-based
//                event model kept in the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grant_event_packer;

    localparam int NR    = 256;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [15:0] ts;
        logic [7:0]  addr;
    } ev_t;

    logic            clk_i;
    logic            rst_i;
    logic [NR-1:0]   gnt_i;
    logic            evt_valid_o;
    logic            evt_ready_i;
    logic [7:0]      evt_addr_o;
    logic [15:0]     evt_ts_o;
    logic [3:0]      fifo_level_o;
    logic [7:0]      ovf_cnt_o;
    logic            multi_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    ev_t          mq[$];
    logic [15:0]  m_ts;
    int           m_ovf;
    bit           m_multi;
    logic [NR-1:0] m_prev;

    grant_event_packer #(
        .NUM_REQUESTS (NR),
        .FIFO_DEPTH   (DEPTH),
        .TS_WIDTH     (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .gnt_i        (gnt_i),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .evt_addr_o   (evt_addr_o),
        .evt_ts_o     (evt_ts_o),
        .fifo_level_o (fifo_level_o),
        .ovf_cnt_o    (ovf_cnt_o),
        .multi_err_o  (multi_err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [NR-1:0] onehot(input int idx);
        logic [NR-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ts    = 16'd0;
        m_ovf   = 0;
        m_multi = 1'b0;
        m_prev  = '0;
    endtask

    // Drive one cycle of inputs, advance the model over the rising edge and
    // return 1 time unit after it, where outputs are compared.
    task automatic step(input logic [NR-1:0] g, input bit rdy);
        bit  pop;
        bit  qual;
        int  lowest;
        gnt_i       = g;
        evt_ready_i = rdy;
        @(posedge clk_i);
        pop  = (mq.size() > 0) && rdy;
        qual = (g != '0);
`ifdef GRANT_EVENT_PACKER_DEDUP_EN
        if (g == m_prev) qual = 1'b0;
`endif
        lowest = 0;
        for (int i = NR - 1; i >= 0; i--) if (g[i]) lowest = i;
        if ($countones(g) > 1) m_multi = 1'b1;
        if (pop) void'(mq.pop_front());
        if (qual) begin
            if (mq.size() < DEPTH) mq.push_back('{ts: m_ts, addr: 8'(lowest)});
            else if (m_ovf < 255) m_ovf++;
        end
        m_prev = g;
        m_ts   = m_ts + 16'd1;
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        gnt_i = '0;
        evt_ready_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++; if (evt_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", evt_valid_o); end
        n_checks++; if (fifo_level_o !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level_o); end
        n_checks++; if (ovf_cnt_o !== 8'd0) begin n_fail++; $display("FAIL reset_ovf: got %0d expected 0", ovf_cnt_o); end
        n_checks++; if (multi_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_multi: got %b expected 0", multi_err_o); end
        n_checks++; if (evt_addr_o !== 8'd0 || evt_ts_o !== 16'd0) begin n_fail++; $display("FAIL reset_head: got addr %0d ts %0d expected 0 0", evt_addr_o, evt_ts_o); end
        rst_i = 1'b0;
        step('0, 1'b0);
        n_checks++; if (evt_valid_o !== 1'b0 || fifo_level_o !== 4'd0) begin n_fail++; $display("FAIL idle_after_reset: got valid %b level %0d expected 0 0", evt_valid_o, fifo_level_o); end
    endtask

    task automatic test_single();
        while (m_ts != 16'd100) step('0, 1'b1);
        step(onehot(5), 1'b1);
        n_checks++; if (evt_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", evt_valid_o); end
        n_checks++; if (evt_addr_o !== 8'd5) begin n_fail++; $display("FAIL single_addr: got %0d expected 5", evt_addr_o); end
        n_checks++; if (evt_ts_o !== 16'd100) begin n_fail++; $display("FAIL single_ts: got %0d expected 100", evt_ts_o); end
        n_checks++; if (fifo_level_o !== 4'd1) begin n_fail++; $display("FAIL single_level: got %0d expected 1", fifo_level_o); end
        step('0, 1'b1);
        n_checks++; if (fifo_level_o !== 4'd0 || evt_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_drain: got level %0d valid %b expected 0 0", fifo_level_o, evt_valid_o); end
        n_checks++; if (evt_addr_o !== 8'd0 || evt_ts_o !== 16'd0) begin n_fail++; $display("FAIL empty_head_zero: got addr %0d ts %0d expected 0 0", evt_addr_o, evt_ts_o); end
    endtask

    task automatic test_hold();
        logic [15:0] t0;
        int exp_n;
`ifdef GRANT_EVENT_PACKER_DEDUP_EN
        exp_n = 1;
`else
        exp_n = 3;
`endif
        while (mq.size() != 0) step('0, 1'b1);
        t0 = m_ts;
        repeat (3) step(onehot(17), 1'b0);
        step('0, 1'b0);
        n_checks++; if (fifo_level_o !== 4'(exp_n)) begin n_fail++; $display("FAIL hold_count: got %0d expected %0d", fifo_level_o, exp_n); end
        for (int k = 0; k < exp_n; k++) begin
            n_checks++;
            if (evt_valid_o !== 1'b1 || evt_addr_o !== 8'd17 || evt_ts_o !== t0 + 16'(k)) begin
                n_fail++;
                $display("FAIL hold_event%0d: got v=%b addr=%0d ts=%0d expected v=1 addr=17 ts=%0d", k, evt_valid_o, evt_addr_o, evt_ts_o, t0 + 16'(k));
            end
            step('0, 1'b1);
        end
        n_checks++; if (evt_valid_o !== 1'b0) begin n_fail++; $display("FAIL hold_empty: got %b expected 0", evt_valid_o); end
    endtask

    task automatic test_overflow();
        logic [15:0] t0;
        int base;
        while (mq.size() != 0) step('0, 1'b1);
        base = m_ovf;
        t0 = m_ts;
        for (int k = 0; k < 10; k++) step(onehot(20 + k), 1'b0);
        n_checks++; if (fifo_level_o !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d expected 8", fifo_level_o); end
        n_checks++; if (ovf_cnt_o !== 8'(base + 2)) begin n_fail++; $display("FAIL ovf_count: got %0d expected %0d", ovf_cnt_o, base + 2); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (evt_valid_o !== 1'b1 || evt_addr_o !== 8'd20 || evt_ts_o !== t0) begin
                n_fail++;
                $display("FAIL ovf_head_stable%0d: got v=%b addr=%0d ts=%0d expected v=1 addr=20 ts=%0d", k, evt_valid_o, evt_addr_o, evt_ts_o, t0);
            end
            step('0, 1'b0);
        end
    endtask

    task automatic test_full_push_pop();
        int ovf0;
        int exp_addr [8] = '{21, 22, 23, 24, 25, 26, 27, 50};
        ovf0 = int'(ovf_cnt_o);
        step(onehot(50), 1'b1);
        n_checks++; if (fifo_level_o !== 4'd8) begin n_fail++; $display("FAIL fullpp_level: got %0d expected 8", fifo_level_o); end
        n_checks++; if (int'(ovf_cnt_o) != ovf0 || ovf_cnt_o !== 8'(m_ovf)) begin n_fail++; $display("FAIL fullpp_ovf: got %0d expected %0d", ovf_cnt_o, m_ovf); end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (evt_valid_o !== 1'b1 || evt_addr_o !== 8'(exp_addr[k])) begin
                n_fail++;
                $display("FAIL fullpp_order%0d: got v=%b addr=%0d expected v=1 addr=%0d", k, evt_valid_o, evt_addr_o, exp_addr[k]);
            end
            step('0, 1'b1);
        end
        n_checks++; if (fifo_level_o !== 4'd0) begin n_fail++; $display("FAIL fullpp_drain: got %0d expected 0", fifo_level_o); end
    endtask

    task automatic test_multi();
        step(onehot(3) | onehot(9), 1'b0);
        n_checks++; if (evt_addr_o !== 8'd3) begin n_fail++; $display("FAIL multi_addr: got %0d expected 3", evt_addr_o); end
        n_checks++; if (multi_err_o !== 1'b1) begin n_fail++; $display("FAIL multi_flag: got %b expected 1", multi_err_o); end
        repeat (3) step(onehot(4), 1'b1);
        step('0, 1'b1);
        n_checks++; if (multi_err_o !== 1'b1) begin n_fail++; $display("FAIL multi_sticky: got %b expected 1", multi_err_o); end
    endtask

    task automatic test_random();
        logic [NR-1:0] g;
        logic [NR-1:0] last;
        ev_t           h;
        int            r;
        last = '0;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      g = '0;
            else if (r < 5) g = last;
            else if (r < 9) g = onehot($urandom_range(0, NR - 1));
            else            g = onehot($urandom_range(0, NR - 1)) | onehot($urandom_range(0, NR - 1));
            last = g;
            step(g, ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1);
            h = (mq.size() > 0) ? mq[0] : '0;
            n_checks++;
            if (evt_valid_o !== (mq.size() > 0) || evt_addr_o !== h.addr || evt_ts_o !== h.ts ||
                fifo_level_o !== 4'(mq.size()) || ovf_cnt_o !== 8'(m_ovf) || multi_err_o !== m_multi) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got v=%b a=%0d ts=%0d lvl=%0d ovf=%0d me=%b expected v=%b a=%0d ts=%0d lvl=%0d ovf=%0d me=%b",
                         n, evt_valid_o, evt_addr_o, evt_ts_o, fifo_level_o, ovf_cnt_o, multi_err_o,
                         mq.size() > 0, h.addr, h.ts, mq.size(), m_ovf, m_multi);
            end
        end
    endtask

    task automatic test_reset_midrun();
        while (m_ts != 16'hFFFA) step('0, 1'b1);
        for (int k = 0; k < 4; k++) step(onehot(40 + k), 1'b0);
        n_checks++; if (fifo_level_o !== 4'd4 || evt_ts_o !== 16'hFFFA || evt_addr_o !== 8'd40) begin n_fail++; $display("FAIL prerst_state: got lvl=%0d ts=%h addr=%0d expected 4 fffa 40", fifo_level_o, evt_ts_o, evt_addr_o); end
        #3;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (evt_valid_o !== 1'b0 || evt_addr_o !== 8'd0 || evt_ts_o !== 16'd0 || fifo_level_o !== 4'd0 ||
            ovf_cnt_o !== 8'd0 || multi_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset_outputs: got v=%b a=%0d ts=%0d lvl=%0d ovf=%0d me=%b expected all 0",
                     evt_valid_o, evt_addr_o, evt_ts_o, fifo_level_o, ovf_cnt_o, multi_err_o);
        end
        gnt_i = onehot(60);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
        step(onehot(77), 1'b0);
        n_checks++; if (evt_valid_o !== 1'b1 || evt_addr_o !== 8'd77) begin n_fail++; $display("FAIL postrst_addr: got v=%b addr=%0d expected v=1 addr=77", evt_valid_o, evt_addr_o); end
        n_checks++; if (evt_ts_o !== 16'd0) begin n_fail++; $display("FAIL postrst_ts: got %0d expected 0", evt_ts_o); end
        n_checks++; if (fifo_level_o !== 4'd1) begin n_fail++; $display("FAIL postrst_level: got %0d expected 1", fifo_level_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_overflow();
        test_full_push_pop();
        test_multi();
        test_random();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
